rx_packet_fsm: RTL and testbench

RX_PACKET_FSM -- requirements
Module: rx_packet_fsm

---
 rtl/rx_packet_fsm.sv | 121 ++++++++++++
 tb/tb_rx_packet_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_fsm.sv
// rx_packet_fsm: byte-stream deframer. Hunts for SOF_VAL, forwards payload
// bytes until EOF_VAL, and flags SOF-inside-packet as a framing error.
// Optional feature: define RX_LEN_CHECK_EN to reject payload beyond MAX_LEN;
// without it pkt_len saturates at 255 and all payload bytes are forwarded.
module rx_packet_fsm #(
    parameter logic [7:0]  SOF_VAL = 8'h7E,
    parameter logic [7:0]  EOF_VAL = 8'h81,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       byte_ready,
    input  logic [7:0] rx_byte,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       packet_done,
    output logic       packet_error,
    output logic [7:0] pkt_len,
    output logic       busy
);

    localparam int unsigned LenW   = 8;
    localparam logic [LenW-1:0] LenSat = LenW'(255);

    // Reject out-of-range length limits at elaboration.
    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("rx_packet_fsm: MAX_LEN must be in 1..255");
    end

`ifdef RX_LEN_CHECK_EN
    localparam logic [LenW-1:0] MaxLenC = LenW'(MAX_LEN);
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_e;

    state_e          state_q;
    logic [7:0]      data_out_q;
    logic            data_valid_q;
    logic            packet_done_q;
    logic            packet_error_q;
    logic [LenW-1:0] pkt_len_q;
    logic            busy_q;

    logic            is_sof_c;
    logic            is_eof_c;

    assign is_sof_c = (rx_byte == SOF_VAL);
    assign is_eof_c = (rx_byte == EOF_VAL);

    // Framing state machine with registered outputs; strobes default low each cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            data_out_q     <= 8'h00;
            data_valid_q   <= 1'b0;
            packet_done_q  <= 1'b0;
            packet_error_q <= 1'b0;
            pkt_len_q      <= '0;
            busy_q         <= 1'b0;
        end else begin
            data_valid_q   <= 1'b0;
            packet_done_q  <= 1'b0;
            packet_error_q <= 1'b0;
            if (byte_ready) begin
                unique case (state_q)
                    IDLE: begin
                        if (is_sof_c) begin
                            state_q   <= IN_PKT;
                            busy_q    <= 1'b1;
                            pkt_len_q <= '0;
                        end
                    end
                    IN_PKT: begin
                        if (is_sof_c) begin
                            // Resync: treat the new SOF as the start of a fresh packet.
                            packet_error_q <= 1'b1;
                            pkt_len_q      <= '0;
                        end else if (is_eof_c) begin
                            packet_done_q <= 1'b1;
                            state_q       <= IDLE;
                            busy_q        <= 1'b0;
`ifdef RX_LEN_CHECK_EN
                        end else if (pkt_len_q == MaxLenC) begin
                            packet_error_q <= 1'b1;
                            state_q        <= IDLE;
                            busy_q         <= 1'b0;
                        end else begin
                            data_out_q   <= rx_byte;
                            data_valid_q <= 1'b1;
                            pkt_len_q    <= pkt_len_q + LenW'(1);
                        end
`else
                        end else begin
                            data_out_q   <= rx_byte;
                            data_valid_q <= 1'b1;
                            if (pkt_len_q != LenSat) begin
                                pkt_len_q <= pkt_len_q + LenW'(1);
                            end
                        end
`endif
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign packet_done  = packet_done_q;
    assign packet_error = packet_error_q;
    assign pkt_len      = pkt_len_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rx_packet_fsm.sv
// Directed bench for rx_packet_fsm (MAX_LEN=4 so the length-check build is exercised too).
module tb_rx_packet_fsm;

    logic       clk;
    logic       n_rst;
    logic       byte_ready;
    logic [7:0] rx_byte;
    logic [7:0] data_out;
    logic       data_valid;
    logic       packet_done;
    logic       packet_error;
    logic [7:0] pkt_len;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int dv_count;

    rx_packet_fsm #(
        .SOF_VAL (8'h7E),
        .EOF_VAL (8'h81),
        .MAX_LEN (4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .byte_ready   (byte_ready),
        .rx_byte      (rx_byte),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .packet_done  (packet_done),
        .packet_error (packet_error),
        .pkt_len      (pkt_len),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count and report mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for one edge; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_ready = 1'b1;
        rx_byte    = b;
        @(posedge clk);
        #1;
        if (data_valid) dv_count++;
    endtask

    // One cycle with no byte.
    task automatic gap();
        @(negedge clk);
        byte_ready = 1'b0;
        rx_byte    = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic check_strobes(input string tag, input logic dv, input logic done, input logic err);
        check({tag, "_dv"},   32'(data_valid),   32'(dv));
        check({tag, "_done"}, 32'(packet_done),  32'(done));
        check({tag, "_err"},  32'(packet_error), 32'(err));
    endtask

    initial begin
        n_rst      = 1'b0;
        byte_ready = 1'b0;
        rx_byte    = 8'h00;
        dv_count   = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_data",   32'(data_out), 32'h00);
        check("rst_len",    32'(pkt_len),  32'h00);
        check("rst_busy",   32'(busy),     32'h0);
        check_strobes("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;

        // Basic packet 7E 11 22 33 81
        send(8'h7E);
        check("p1_sof_busy", 32'(busy), 32'h1);
        check("p1_sof_len",  32'(pkt_len), 32'h0);
        check_strobes("p1_sof", 1'b0, 1'b0, 1'b0);
        send(8'h11);
        check_strobes("p1_b1", 1'b1, 1'b0, 1'b0);
        check("p1_b1_data", 32'(data_out), 32'h11);
        check("p1_b1_len",  32'(pkt_len),  32'h1);
        send(8'h22);
        check("p1_b2_data", 32'(data_out), 32'h22);
        send(8'h33);
        check("p1_b3_data", 32'(data_out), 32'h33);
        check("p1_b3_len",  32'(pkt_len),  32'h3);
        send(8'h81);
        check_strobes("p1_eof", 1'b0, 1'b1, 1'b0);
        check("p1_eof_len",  32'(pkt_len), 32'h3);
        check("p1_eof_busy", 32'(busy),    32'h0);
        gap();
        check_strobes("p1_gap", 1'b0, 1'b0, 1'b0);
        check("p1_gap_data", 32'(data_out), 32'h33);
        check("p1_gap_len",  32'(pkt_len),  32'h3);

        // Junk in IDLE then empty packet: 55 81 7E 81
        dv_count = 0;
        send(8'h55);
        check_strobes("p2_junk", 1'b0, 1'b0, 1'b0);
        check("p2_junk_busy", 32'(busy), 32'h0);
        check("p2_junk_len",  32'(pkt_len), 32'h3);
        send(8'h81);
        check_strobes("p2_eof0", 1'b0, 1'b0, 1'b0);
        send(8'h7E);
        check("p2_sof_len", 32'(pkt_len), 32'h0);
        send(8'h81);
        check_strobes("p2_eof", 1'b0, 1'b1, 1'b0);
        check("p2_eof_len", 32'(pkt_len), 32'h0);
        check("p2_dv_cnt",  32'(dv_count), 32'd0);
        gap();

        // Resync: 7E AA 7E BB 81
        send(8'h7E);
        send(8'hAA);
        check_strobes("p3_aa", 1'b1, 1'b0, 1'b0);
        check("p3_aa_data", 32'(data_out), 32'hAA);
        send(8'h7E);
        check_strobes("p3_resync", 1'b0, 1'b0, 1'b1);
        check("p3_resync_len",  32'(pkt_len), 32'h0);
        check("p3_resync_busy", 32'(busy),    32'h1);
        check("p3_resync_data", 32'(data_out), 32'hAA);
        send(8'hBB);
        check_strobes("p3_bb", 1'b1, 1'b0, 1'b0);
        check("p3_bb_data", 32'(data_out), 32'hBB);
        send(8'h81);
        check_strobes("p3_eof", 1'b0, 1'b1, 1'b0);
        check("p3_eof_len", 32'(pkt_len), 32'h1);
        gap();

        // Length limit with MAX_LEN=4: 7E then 5 payload bytes
        dv_count = 0;
        send(8'h7E);
        for (int i = 1; i <= 4; i++) send(8'(i));
        check("p4_len4", 32'(pkt_len), 32'h4);
        send(8'h05);
`ifdef RX_LEN_CHECK_EN
        check_strobes("p4_over", 1'b0, 1'b0, 1'b1);
        check("p4_over_busy", 32'(busy),     32'h0);
        check("p4_over_len",  32'(pkt_len),  32'h4);
        check("p4_over_data", 32'(data_out), 32'h04);
        check("p4_dv_cnt",    32'(dv_count), 32'd4);
`else
        check_strobes("p4_over", 1'b1, 1'b0, 1'b0);
        check("p4_over_len",  32'(pkt_len),  32'h5);
        check("p4_over_data", 32'(data_out), 32'h05);
        check("p4_dv_cnt",    32'(dv_count), 32'd5);
        send(8'h81);
        check_strobes("p4_eof", 1'b0, 1'b1, 1'b0);
`endif
        gap();

        // Asynchronous reset mid-packet: 7E 01 02 then n_rst low between edges
        send(8'h7E);
        send(8'h01);
        send(8'h02);
        check("p5_pre_dv", 32'(data_valid), 32'h1);
        #2;
        n_rst      = 1'b0;
        byte_ready = 1'b0;
        #1;
        check("p5_rst_data", 32'(data_out), 32'h00);
        check("p5_rst_len",  32'(pkt_len),  32'h00);
        check("p5_rst_busy", 32'(busy),     32'h0);
        check_strobes("p5_rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_strobes("p5_hold", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        send(8'h7E);
        check("p5_sof_busy", 32'(busy), 32'h1);
        send(8'h03);
        check("p5_b_data", 32'(data_out), 32'h03);
        send(8'h81);
        check_strobes("p5_eof", 1'b0, 1'b1, 1'b0);
        check("p5_eof_len", 32'(pkt_len), 32'h1);
        gap();

`ifndef RX_LEN_CHECK_EN
        // Saturation: 300 payload bytes, pkt_len sticks at 255, data still forwarded
        send(8'h7E);
        for (int i = 0; i < 300; i++) send(8'h10 + 8'(i % 64));
        check("p6_sat_len",  32'(pkt_len),    32'd255);
        check("p6_sat_dv",   32'(data_valid), 32'h1);
        check("p6_sat_data", 32'(data_out),   32'h10 + 32'(299 % 64));
        send(8'h81);
        check_strobes("p6_eof", 1'b0, 1'b1, 1'b0);
        check("p6_eof_len", 32'(pkt_len), 32'd255);
        gap();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
